wiper_motor_seq: RTL and testbench



---
 rtl/wiper_pkg.sv | 9 +
 rtl/wiper_motor_seq_if.sv | 15 +
 rtl/wiper_step_timer.sv | 20 ++
 rtl/wiper_motor_seq.sv | 74 +++++++
 tb/tb_wiper_motor_seq.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/wiper_pkg.sv
// wiper_pkg: shared types and default geometry for the wiper motor sequencer
package wiper_pkg;
    // Encoding shared with the upstream rain-sensing speed controller
    typedef enum logic [1:0] {OFF = 2'd0, SLOW = 2'd1, FAST = 2'd2} speed_t;
    typedef enum logic [1:0] {PARKED, SWEEP_OUT, SWEEP_BACK} wiper_state_t;
    localparam int NPOS_DEF     = 8;
    localparam int SLOW_DIV_DEF = 4;
    localparam int FAST_DIV_DEF = 1;
endpackage

// File: rtl/wiper_motor_seq_if.sv
// wiper_motor_seq_if: speed command in, motor/LCD status out
interface wiper_motor_seq_if
    import wiper_pkg::*;
#(
    parameter int NPOS = NPOS_DEF
);
    logic [1:0]              speed_cmd;
    logic                    motor_on;
    logic                    dir;
    logic                    parked;
    logic [$clog2(NPOS)-1:0] position;
    logic [7:0]              sweep_count;
    modport master (output speed_cmd, input motor_on, dir, parked, position, sweep_count);
    modport slave  (input speed_cmd, output motor_on, dir, parked, position, sweep_count);
endinterface

// File: rtl/wiper_step_timer.sv
// wiper_step_timer: divides clk_1 down to one position step every div cycles
module wiper_step_timer #(
    parameter int W = 2
) (
    input  logic         clk_1,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W:0]   div,
    output logic         step
);
    logic [W-1:0] div_cnt;
    always_comb step = ({1'b0, div_cnt} == div - (W+1)'(1));
    always_ff @(posedge clk_1) begin
        if (reset || clear)
            div_cnt <= '0;
        else if (enable)
            div_cnt <= step ? '0 : div_cnt + W'(1);
    end
endmodule

// File: rtl/wiper_motor_seq.sv
// wiper_motor_seq: turns the speed command into out-and-back arm sweeps that
// always finish at park
module wiper_motor_seq
    import wiper_pkg::*;
#(
    parameter int NPOS     = NPOS_DEF,
    parameter int SLOW_DIV = SLOW_DIV_DEF,
    parameter int FAST_DIV = FAST_DIV_DEF
) (
    input logic               clk_1,
    input logic               reset,
    wiper_motor_seq_if.slave  bus
);
    localparam int PW = $clog2(NPOS);
    localparam int W  = SLOW_DIV > 1 ? $clog2(SLOW_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(NPOS - 1);
    wiper_state_t  state_q, state_d;
    speed_t        spd_q, spd_d, cmd;
    logic [PW-1:0] pos_q, pos_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          step, active, chg, adv, fwd;
    wiper_step_timer #(.W(W)) u_timer (
        .clk_1  (clk_1),
        .reset  (reset),
        .clear  (state_q == PARKED || chg),
        .enable (state_q != PARKED),
        .div    (spd_q == FAST ? (W+1)'(FAST_DIV) : (W+1)'(SLOW_DIV)),
        .step   (step)
    );
    always_ff @(posedge clk_1) begin
        if (reset) begin
            state_q <= PARKED;
            pos_q   <= '0;
            spd_q   <= SLOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            spd_q   <= spd_d;
            cnt_q   <= cnt_d;
        end
    end
    // A speed change restarts the divider and swallows any step due this cycle
    always_comb begin
        cmd     = speed_t'(bus.speed_cmd);
        active  = cmd == SLOW || cmd == FAST;
        chg     = active && state_q != PARKED && cmd != spd_q;
        adv     = step && !chg && state_q != PARKED;
        fwd     = state_q == SWEEP_OUT && pos_q != PMAX;
        state_d = state_q;
        pos_d   = pos_q;
        spd_d   = chg ? cmd : spd_q;
        cnt_d   = cnt_q;
        if (state_q == PARKED && active) begin
            state_d = SWEEP_OUT;
            spd_d   = cmd;
        end else if (adv) begin
            pos_d   = fwd ? pos_q + PW'(1) : pos_q - PW'(1);
            state_d = fwd ? SWEEP_OUT : SWEEP_BACK;
            if (pos_d == '0) begin
                cnt_d   = cnt_q + 8'd1;
                state_d = active ? SWEEP_OUT : PARKED;
                spd_d   = active ? cmd : spd_q;
            end
        end
    end
    always_comb begin
        bus.motor_on    = state_q != PARKED;
        bus.dir         = state_q == SWEEP_BACK;
        bus.parked      = state_q == PARKED;
        bus.position    = pos_q;
        bus.sweep_count = cnt_q;
    end
endmodule

// File: tb/tb_wiper_motor_seq.sv
// tb_wiper_motor_seq: directed checks of sweep timing, parking, speed change and reset
module tb_wiper_motor_seq;
    logic clk_1 = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    wiper_motor_seq_if bus ();
    wiper_motor_seq dut (.clk_1(clk_1), .reset(reset), .bus(bus));
    always #5 clk_1 = ~clk_1;

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.speed_cmd = 2'd0;
        tick();
        reset = 1'b0;
    endtask

    function automatic int tri_pos(input int s);
        return s <= 7 ? s : 14 - s;
    endfunction

    initial begin
        bus.speed_cmd = 2'd0;
        do_reset();
        chk("rst_parked", bus.parked, 1);
        chk("rst_motor", bus.motor_on, 0);
        chk("rst_dir", bus.dir, 0);
        chk("rst_pos", bus.position, 0);
        chk("rst_count", bus.sweep_count, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_parked", bus.parked, 1);
            chk("idle_motor", bus.motor_on, 0);
            chk("idle_pos", bus.position, 0);
            chk("idle_count", bus.sweep_count, 0);
        end

        // fast, continuous: one position per cycle, 14 cycles per sweep
        bus.speed_cmd = 2'd2;
        tick();
        chk("fast_start_motor", bus.motor_on, 1);
        chk("fast_start_parked", bus.parked, 0);
        chk("fast_start_pos", bus.position, 0);
        for (int i = 1; i <= 28; i++) begin
            tick();
            chk("fast_pos", bus.position, tri_pos(i % 14));
            chk("fast_dir", bus.dir, (i % 14) >= 8);
            chk("fast_motor", bus.motor_on, 1);
            chk("fast_count", bus.sweep_count, i / 14);
        end
        bus.speed_cmd = 2'd0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("fast_off_pos", bus.position, tri_pos(i));
            chk("fast_off_parked", bus.parked, i == 14);
            chk("fast_off_motor", bus.motor_on, i != 14);
            chk("fast_off_count", bus.sweep_count, 2 + (i == 14));
        end

        // slow one-shot command finishes a full 56-cycle sweep then parks
        do_reset();
        bus.speed_cmd = 2'd1;
        tick();
        bus.speed_cmd = 2'd0;
        chk("slow_start_motor", bus.motor_on, 1);
        for (int t = 1; t <= 56; t++) begin
            tick();
            chk("slow_pos", bus.position, tri_pos(t / 4));
            chk("slow_parked", bus.parked, t == 56);
            chk("slow_count", bus.sweep_count, t == 56);
        end
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("slow_stay_parked", bus.parked, 1);
        end

        // slow -> fast at position 3 mid-divider
        do_reset();
        bus.speed_cmd = 2'd1;
        tick();
        for (int t = 1; t <= 13; t++) begin
            tick();
            chk("chg_slow_pos", bus.position, t / 4);
        end
        bus.speed_cmd = 2'd2;
        tick();
        chk("chg_hold_pos", bus.position, 3);
        for (int j = 1; j <= 11; j++) begin
            tick();
            chk("chg_fast_pos", bus.position, tri_pos(3 + j));
            chk("chg_fast_count", bus.sweep_count, j == 11);
        end
        chk("chg_continue_motor", bus.motor_on, 1);

        // speed change on the returning-to-0 step defers that step
        do_reset();
        bus.speed_cmd = 2'd2;
        tick();
        for (int i = 1; i <= 13; i++) tick();
        chk("defer_pre_pos", bus.position, 1);
        chk("defer_pre_dir", bus.dir, 1);
        bus.speed_cmd = 2'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("defer_hold_pos", bus.position, 1);
            chk("defer_hold_count", bus.sweep_count, 0);
        end
        tick();
        chk("defer_done_pos", bus.position, 0);
        chk("defer_done_count", bus.sweep_count, 1);
        chk("defer_done_motor", bus.motor_on, 1);
        chk("defer_done_dir", bus.dir, 0);

        // reset mid-sweep at position 5 on the way back
        do_reset();
        bus.speed_cmd = 2'd2;
        tick();
        for (int i = 1; i <= 9; i++) tick();
        chk("midrst_pre_pos", bus.position, 5);
        chk("midrst_pre_dir", bus.dir, 1);
        reset = 1'b1;
        tick();
        chk("midrst_pos", bus.position, 0);
        chk("midrst_parked", bus.parked, 1);
        chk("midrst_motor", bus.motor_on, 0);
        chk("midrst_count", bus.sweep_count, 0);
        reset = 1'b0;
        bus.speed_cmd = 2'd0;

        // reserved command is treated as off
        bus.speed_cmd = 2'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rsv_parked", bus.parked, 1);
            chk("rsv_pos", bus.position, 0);
        end

        // sweep_count wraps 255 -> 0
        bus.speed_cmd = 2'd2;
        tick();
        repeat (255 * 14) tick();
        chk("wrap_255", bus.sweep_count, 255);
        chk("wrap_255_pos", bus.position, 0);
        repeat (14) tick();
        chk("wrap_0", bus.sweep_count, 0);
        chk("wrap_0_motor", bus.motor_on, 1);
        bus.speed_cmd = 2'd0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
